// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and edge-detect the
// player buttons, then encode single/multi press events.
module button_conditioner #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic             press_valid,
  output logic [2:0]       press_idx,
  output logic             multi_press
);

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int PW = $clog2(N_BTN + 1);

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;
  logic [N_BTN-1:0] lvl_q, lvl_d;
  logic [N_BTN-1:0] lvl_prev_q, lvl_prev_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic             valid_q, valid_d;
  logic [2:0]       idx_q, idx_d;
  logic             multi_q, multi_d;

  logic [N_BTN-1:0] rise;
  logic [PW-1:0]    n_set;
  logic [2:0]       hit;

  // Two-stage synchroniser per channel.
  always_comb begin
    s1_d = btn_raw;
    s2_d = s1_q;
  end

  // Accept a new level only after an unbroken run of mismatches;
  // any match clears the run so glitches never accumulate.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == TERM) begin
          lvl_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Gated rising edges feed both the pulse vector and the encoder,
  // so the two always agree in the same cycle.
  always_comb begin
    lvl_prev_d = lvl_q;
    rise       = lvl_q & ~lvl_prev_q & {N_BTN{en}};
    pulse_d    = rise;
    n_set      = '0;
    hit        = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (rise[i]) begin
        n_set = n_set + PW'(1);
        hit   = 3'(i);
      end
    end
    valid_d = (n_set == PW'(1));
    multi_d = (n_set > PW'(1));
    idx_d   = valid_d ? hit : 3'd0;
  end

  // State registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      pulse_q    <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      multi_q    <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      pulse_q    <= pulse_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      multi_q    <= multi_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = lvl_q;
  assign press_pulse = pulse_q;
  assign press_valid = valid_q;
  assign press_idx   = idx_q;
  assign multi_press = multi_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scenario tasks plus random stimulus,
// compared every cycle against a sliding-window reference model.
module tb_button_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] btn_raw = 8'h00;
  logic [7:0] btn_level;
  logic [7:0] press_pulse;
  logic       press_valid;
  logic [2:0] press_idx;
  logic       multi_press;

  int checks = 0;
  int passes = 0;

  button_conditioner #(
    .N_BTN(8),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .press_valid(press_valid),
    .press_idx(press_idx),
    .multi_press(multi_press)
  );

  always #5 clk = ~clk;

  // Reference model: h[0] is the newest raw sample taken at a clock
  // edge; the level flips once the D samples visible through the
  // two-cycle synchroniser all disagree with it.
  logic [7:0] h [0:D];
  logic [7:0] m_lvl = 8'h00;
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_pulse = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_multi = 1'b0;
  logic [2:0] m_idx = 3'd0;

  function automatic logic [2:0] idx_of(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    if ($countones(v) == 1)
      for (int i = 0; i < 8; i++)
        if (v[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [7:0] next_lvl(
    input logic [7:0] cur,
    input logic [7:0] w1, input logic [7:0] w2,
    input logic [7:0] w3, input logic [7:0] w4
  );
    logic [7:0] differ;
    differ = (w1 ^ cur) & (w2 ^ cur) & (w3 ^ cur) & (w4 ^ cur);
    return cur ^ differ;
  endfunction

  logic [7:0] m_rise;
  assign m_rise = en ? (m_lvl & ~m_prev) : 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= D; j++) h[j] <= 8'h00;
      m_lvl   <= 8'h00;
      m_prev  <= 8'h00;
      m_pulse <= 8'h00;
      m_valid <= 1'b0;
      m_multi <= 1'b0;
      m_idx   <= 3'd0;
    end else begin
      m_pulse <= m_rise;
      m_valid <= ($countones(m_rise) == 1);
      m_multi <= ($countones(m_rise) > 1);
      m_idx   <= idx_of(m_rise);
      m_prev  <= m_lvl;
      m_lvl   <= next_lvl(m_lvl, h[1], h[2], h[3], h[4]);
      h[0]    <= btn_raw;
      for (int j = 1; j <= D; j++) h[j] <= h[j-1];
    end
  end

  logic [20:0] obs_v, exp_v;
  assign obs_v = {btn_level, press_pulse, press_valid,
                  press_idx, multi_press};
  assign exp_v = {m_lvl, m_pulse, m_valid, m_idx, m_multi};

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== 21'd0)
        $display("FAIL reset_hold: got %h want 0", obs_v);
      else passes++;
    end
    rst_n = 1'b1;
    btn_raw = 8'hFF;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_v !== 21'd0)
      $display("FAIL reset_async: got %h want 0", obs_v);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v)
        $display("FAIL reset_track: got %h want %h", obs_v, exp_v);
      else passes++;
      if (i == 4 || i == 5 || i == 6 || i == 7) begin
        checks++;
        case (i)
          4: if (btn_level !== 8'h00)
               $display("FAIL reset_lvl_early: got %h want 00",
                        btn_level);
             else passes++;
          5: if (btn_level !== 8'hFF || press_pulse !== 8'h00)
               $display("FAIL reset_lvl: got %h/%h want ff/00",
                        btn_level, press_pulse);
             else passes++;
          6: if (press_pulse !== 8'hFF || multi_press !== 1'b1 ||
                 press_valid !== 1'b0 || press_idx !== 3'd0)
               $display("FAIL reset_multi: got %h %b %b %0d",
                        press_pulse, multi_press, press_valid,
                        press_idx);
             else passes++;
          default: if (press_pulse !== 8'h00 || multi_press !== 1'b0)
               $display("FAIL reset_one_cycle: got %h %b want 00 0",
                        press_pulse, multi_press);
             else passes++;
        endcase
      end
    end
    btn_raw = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v)
        $display("FAIL reset_rel: got %h want %h", obs_v, exp_v);
      else passes++;
    end
  endtask

  task automatic test_clean_press();
    int rel_pulses;
    btn_raw = 8'h20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v)
        $display("FAIL clean_track: got %h want %h", obs_v, exp_v);
      else passes++;
      if (i == 6) begin
        checks++;
        if (press_pulse !== 8'h20 || press_valid !== 1'b1 ||
            press_idx !== 3'd5 || multi_press !== 1'b0)
          $display("FAIL clean_pulse: got %h %b %0d %b",
                   press_pulse, press_valid, press_idx, multi_press);
        else passes++;
      end
    end
    btn_raw = 8'h00;
    rel_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (press_pulse != 8'h00 || press_valid) rel_pulses++;
      if (i == 5) begin
        checks++;
        if (btn_level !== 8'h00)
          $display("FAIL clean_release: got %h want 00", btn_level);
        else passes++;
      end
    end
    checks++;
    if (rel_pulses !== 0)
      $display("FAIL clean_no_rel_pulse: got %0d want 0", rel_pulses);
    else passes++;
  endtask

  task automatic test_bounce();
    logic [7:0] pat [8] = '{8'h04, 8'h04, 8'h00, 8'h00,
                           8'h04, 8'h04, 8'h00, 8'h00};
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      btn_raw = (i < 8) ? pat[i] : 8'h00;
      @(negedge clk);
      if (btn_level != 8'h00 || press_pulse != 8'h00) bad++;
      checks++;
      if (obs_v !== exp_v)
        $display("FAIL bounce_track: got %h want %h", obs_v, exp_v);
      else passes++;
    end
    checks++;
    if (bad !== 0)
      $display("FAIL bounce_reject: got %0d active cycles want 0", bad);
    else passes++;
  endtask

  task automatic test_bounce_settle();
    int np;
    np = 0;
    btn_raw = 8'h04;
    repeat (3) @(negedge clk);
    btn_raw = 8'h00;
    repeat (2) begin
      @(negedge clk);
      if (press_valid) np++;
    end
    btn_raw = 8'h04;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (press_valid) np++;
      checks++;
      if (obs_v !== exp_v)
        $display("FAIL settle_track: got %h want %h", obs_v, exp_v);
      else passes++;
      if (i == 6) begin
        checks++;
        if (press_pulse !== 8'h04 || press_idx !== 3'd2)
          $display("FAIL settle_time: got %h %0d want 04 2",
                   press_pulse, press_idx);
        else passes++;
      end
    end
    checks++;
    if (np !== 1)
      $display("FAIL settle_count: got %0d want 1", np);
    else passes++;
    btn_raw = 8'h00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int nv;
    logic [2:0] seen [2];
    btn_raw = 8'h09;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v)
        $display("FAIL simul_track: got %h want %h", obs_v, exp_v);
      else passes++;
      if (i == 6) begin
        checks++;
        if (press_pulse !== 8'h09 || multi_press !== 1'b1 ||
            press_valid !== 1'b0 || press_idx !== 3'd0)
          $display("FAIL simul_multi: got %h %b %b %0d",
                   press_pulse, multi_press, press_valid, press_idx);
        else passes++;
      end
    end
    btn_raw = 8'h00;
    repeat (10) @(negedge clk);
    nv = 0;
    seen[0] = 3'd7;
    seen[1] = 3'd7;
    btn_raw = 8'h01;
    @(negedge clk);
    btn_raw = 8'h09;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (multi_press) nv += 10;
      if (press_valid) begin
        if (nv < 2) seen[nv] = press_idx;
        nv++;
      end
      checks++;
      if (obs_v !== exp_v)
        $display("FAIL stagger_track: got %h want %h", obs_v, exp_v);
      else passes++;
    end
    checks++;
    if (nv !== 2 || seen[0] !== 3'd0 || seen[1] !== 3'd3)
      $display("FAIL stagger: got n=%0d idx %0d,%0d want 2 0,3",
               nv, seen[0], seen[1]);
    else passes++;
    btn_raw = 8'h00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_enable();
    int np;
    np = 0;
    en = 1'b0;
    btn_raw = 8'h80;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (press_pulse != 8'h00 || press_valid || multi_press) np++;
    end
    checks++;
    if (btn_level !== 8'h80 || np !== 0)
      $display("FAIL en_off: got lvl %h pulses %0d want 80 0",
               btn_level, np);
    else passes++;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (press_pulse != 8'h00 || press_valid) np++;
    end
    checks++;
    if (np !== 0)
      $display("FAIL en_rise_held: got %0d pulses want 0", np);
    else passes++;
    btn_raw = 8'h00;
    repeat (10) @(negedge clk);
    btn_raw = 8'h80;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (press_valid && press_idx == 3'd7) np++;
      checks++;
      if (obs_v !== exp_v)
        $display("FAIL en_track: got %h want %h", obs_v, exp_v);
      else passes++;
    end
    checks++;
    if (np !== 1)
      $display("FAIL en_repress: got %0d idx7 events want 1", np);
    else passes++;
    btn_raw = 8'h00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v)
        $display("FAIL random_c%0d: got %h want %h", i, obs_v, exp_v);
      else passes++;
      r = $urandom & $urandom & $urandom;
      if ($urandom_range(3, 0) == 0) btn_raw = btn_raw ^ r[7:0];
      if ($urandom_range(59, 0) == 0) en = ~en;
    end
    en = 1'b1;
    btn_raw = 8'h00;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_bounce_settle();
    test_simultaneous();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
